// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronizes 16 asynchronous request lines, detects new
// requests (rising edge or level), and holds them as sticky pending bits that
// are cleared by an indexed acknowledge. A writable mask gates what the
// downstream priority encoder sees, without affecting what is latched.
module irq_pending_latch #(
  parameter int unsigned SYNC_STAGES = 2,  // 2 or 3 flops per request line
  parameter bit          LEVEL_MODE  = 1'b0 // 0: rising-edge detect, 1: level detect
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_in,
  input  logic        ack_valid,
  input  logic [3:0]  ack_idx,
  input  logic        mask_wr,
  input  logic [15:0] mask_data,
  output logic [15:0] pending_raw,
  output logic [15:0] pending_out,
  output logic        any_pending,
  output logic [15:0] overrun,
  output logic        ack_err
);

  // Synchronizer chain, one 16-bit word per stage; stage 0 samples req_in.
  logic [15:0] sync_q [SYNC_STAGES];
  logic [15:0] hist_q;
  logic [15:0] pend_q, pend_d;
  logic [15:0] ovr_q,  ovr_d;
  logic [15:0] mask_q, mask_d;
  logic        ack_err_q, ack_err_d;

  logic [15:0] sync_last;
  logic [15:0] rise;
  logic [15:0] detect;
  logic [15:0] ack_vec;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Synchronizer stages and history flop; all cleared so a line already high
  // at reset release looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      hist_q <= sync_last;
    end
  end

  // Detect terms, acknowledge decode and next-state for pending/overrun/mask.
  // Overrun always keys off a new rising edge, so in level mode a line held
  // continuously high keeps its pending bit alive without flagging overrun.
  // A detect on the acknowledged bit wins: pending stays set and overrun is
  // neither cleared nor set.
  always_comb begin
    rise      = sync_last & ~hist_q;
    detect    = LEVEL_MODE ? sync_last : rise;
    ack_vec   = ack_valid ? (16'd1 << ack_idx) : '0;
    pend_d    = (pend_q & ~ack_vec) | detect;
    ovr_d     = (ovr_q & ~(ack_vec & ~detect)) | (rise & pend_q & ~ack_vec);
    ack_err_d = ack_valid & ~pend_q[ack_idx];
    mask_d    = mask_wr ? mask_data : mask_q;
  end

  // Pending, overrun, ack error and mask registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= '0;
      ovr_q     <= '0;
      ack_err_q <= 1'b0;
      mask_q    <= '1;
    end else begin
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      ack_err_q <= ack_err_d;
      mask_q    <= mask_d;
    end
  end

  // Encoder-facing outputs depend only on registered state.
  always_comb begin
    pending_raw = pend_q;
    pending_out = pend_q & mask_q;
    any_pending = |(pend_q & mask_q);
    overrun     = ovr_q;
    ack_err     = ack_err_q;
  end

endmodule
